// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback,
// decodes datapath strobes from the state register, counts retired instructions, traps on bad encodings.
module multicycle_control #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instruction,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IorD,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          PCSource,
    output logic                ALUSrcA,
    output logic [1:0]          ALUScr,
    output logic [3:0]          ALUControl,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_ALU_WB   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WB   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_ADDI_EX  = 4'd8;
    localparam logic [3:0] S_ADDI_WB  = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h20:   return ALU_ADD;
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h27:   return ALU_NOR;
            6'h2A:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    logic [3:0]          state_r;
    logic [3:0]          next_state_s;
    logic                retire_s;
    logic [RETIRE_W-1:0] retired_r;
    logic                illegal_r;
    logic [5:0]          opcode_s;
    logic [5:0]          funct_s;
    logic                unused_fields_s;

    assign opcode_s        = instruction[31:26];
    assign funct_s         = instruction[5:0];
    assign unused_fields_s = ^instruction[25:6];

    logic       mem_read_s;
    logic       mem_write_s;
    logic       iord_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic [1:0] pc_source_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [3:0] alu_control_s;
    logic       reg_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;

    // Next-state selection and retire detection
    always_comb begin
        next_state_s = state_r;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_RTYPE: begin
                        if (funct_legal(funct_s)) begin
                            next_state_s = S_EXEC_R;
                        end else begin
                            next_state_s = S_TRAP;
                        end
                    end
                    OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
                    OP_ADDI:      next_state_s = S_ADDI_EX;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_J:         next_state_s = S_JUMP;
                    default:      next_state_s = S_TRAP;
                endcase
            end
            S_EXEC_R: next_state_s = S_ALU_WB;
            S_MEM_ADDR: begin
                if (opcode_s == OP_LW) begin
                    next_state_s = S_MEM_RD;
                end else begin
                    next_state_s = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    next_state_s = S_MEM_WB;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = S_MEM_WR;
                end
            end
            S_ADDI_EX: next_state_s = S_ADDI_WB;
            S_ALU_WB, S_MEM_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_TRAP:  next_state_s = S_TRAP;
            // A corrupted state register is treated as a trap rather than guessed at
            default: next_state_s = S_TRAP;
        endcase
    end

    // State, retire counter and sticky trap flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_FETCH;
            retired_r <= {RETIRE_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (retire_s) begin
                retired_r <= retired_r + {{(RETIRE_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
            illegal_r <= illegal_r | (next_state_s == S_TRAP);
        end
    end

    // Strobe decode from the current state, mem_ready and Zero
    always_comb begin
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        iord_s        = 1'b0;
        ir_write_s    = 1'b0;
        pc_write_s    = 1'b0;
        pc_source_s   = 2'b00;
        alu_src_a_s   = 1'b0;
        alu_src_b_s   = 2'b00;
        alu_control_s = 4'b0000;
        reg_write_s   = 1'b0;
        reg_dst_s     = 1'b0;
        mem_to_reg_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read_s    = 1'b1;
                alu_src_b_s   = 2'b01;
                alu_control_s = ALU_ADD;
                ir_write_s    = mem_ready;
                pc_write_s    = mem_ready;
            end
            S_DECODE: begin
                alu_src_b_s   = 2'b11;
                alu_control_s = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a_s   = 1'b1;
                alu_control_s = funct_alu(funct_s);
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a_s   = 1'b1;
                alu_src_b_s   = 2'b10;
                alu_control_s = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            S_ADDI_WB: reg_write_s = 1'b1;
            S_BRANCH: begin
                alu_src_a_s   = 1'b1;
                alu_control_s = ALU_SUB;
                pc_source_s   = 2'b01;
                pc_write_s    = Zero;
            end
            S_JUMP: begin
                pc_source_s = 2'b10;
                pc_write_s  = 1'b1;
            end
            S_TRAP:  mem_read_s = 1'b0;
            default: mem_read_s = 1'b0;
        endcase
    end

    // Reset suppresses every strobe immediately, independent of the state register
    assign MemRead    = rst & mem_read_s;
    assign MemWrite   = rst & mem_write_s;
    assign IorD       = rst & iord_s;
    assign IRWrite    = rst & ir_write_s;
    assign PCWrite    = rst & pc_write_s;
    assign PCSource   = rst ? pc_source_s : 2'b00;
    assign ALUSrcA    = rst & alu_src_a_s;
    assign ALUScr     = rst ? alu_src_b_s : 2'b00;
    assign ALUControl = rst ? alu_control_s : 4'b0000;
    assign RegWrite   = rst & reg_write_s;
    assign RegDst     = rst & reg_dst_s;
    assign MemtoReg   = rst & mem_to_reg_s;
    assign illegal    = illegal_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a driver pushes per-cycle expectations built
// from per-instruction cycle tables; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   instruction = 32'd0;
    logic          zero_in = 1'b0;
    logic          mem_ready = 1'b0;
    logic          MemRead, MemWrite, IorD, IRWrite, PCWrite, ALUSrcA;
    logic [1:0]    PCSource, ALUScr;
    logic [3:0]    ALUControl;
    logic          RegWrite, RegDst, MemtoReg, illegal;
    logic [RW-1:0] retired;

    multicycle_control #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .Zero(zero_in),
        .mem_ready(mem_ready), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
        .ALUScr(ALUScr), .ALUControl(ALUControl), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111, A_NOR = 4'b1100;

    typedef logic [18+RW:0] exp_t;
    exp_t          exp_q[$];
    string         name_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [RW-1:0] m_ret = '0;
    logic          m_ill = 1'b0;
    logic          rst_drv = 1'b0;
    exp_t          mon_exp;
    exp_t          mon_act;
    string         mon_name;
    logic [5:0]    legal_f [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0]    bad_op  [4] = '{6'h3F, 6'h01, 6'h0D, 6'h2A};

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic logic [17:0] mk(input logic mr, input logic mw, input logic iord,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic asa, input logic [1:0] asb, input logic [3:0] alu,
                                       input logic rw, input logic rd, input logic m2r);
        return {mr, mw, iord, irw, pcw, pcs, asa, asb, alu, rw, rd, m2r};
    endfunction

    // funct table: {legal, ALU code}
    function automatic logic [4:0] funct_op(input logic [5:0] f);
        case (f)
            6'h20:   return {1'b1, A_ADD};
            6'h22:   return {1'b1, A_SUB};
            6'h24:   return {1'b1, A_AND};
            6'h25:   return {1'b1, A_OR};
            6'h27:   return {1'b1, A_NOR};
            6'h2A:   return {1'b1, A_SLT};
            default: return {1'b0, 4'b0000};
        endcase
    endfunction

    task automatic cycle(input logic rdy, input logic z, input logic [17:0] ctl,
                         input logic [31:0] ins, input string nm);
        @(posedge clk);
        #1;
        rst         = rst_drv;
        mem_ready   = rdy;
        zero_in     = z;
        instruction = ins;
        exp_q.push_back({ctl, m_ill, m_ret});
        name_q.push_back(nm);
    endtask

    task automatic do_reset(input int n);
        rst_drv = 1'b0;
        m_ret   = '0;
        m_ill   = 1'b0;
        for (int i = 0; i < n; i++) cycle(rb(), rb(), 18'd0, 32'($urandom), "reset");
        rst_drv = 1'b1;
    endtask

    task automatic trap_cycles(input logic [31:0] ins);
        m_ill = 1'b1;
        for (int i = 0; i < 22; i++) cycle(rb(), rb(), 18'd0, ins, "trap");
        do_reset(2);
    endtask

    task automatic fetch_decode(input logic [31:0] ins, input int wf);
        for (int i = 0; i < wf; i++)
            cycle(1'b0, rb(), mk(1,0,0,0,0,2'b00,0,2'b01,A_ADD,0,0,0), ins, "fetch_wait");
        cycle(1'b1, rb(), mk(1,0,0,1,1,2'b00,0,2'b01,A_ADD,0,0,0), ins, "fetch");
        cycle(rb(), rb(), mk(0,0,0,0,0,2'b00,0,2'b11,A_ADD,0,0,0), ins, "decode");
    endtask

    task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic z);
        logic [4:0] fo;
        fo = funct_op(ins[5:0]);
        fetch_decode(ins, wf);
        case (ins[31:26])
            6'h00: begin
                if (fo[4]) begin
                    cycle(rb(), rb(), mk(0,0,0,0,0,2'b00,1,2'b00,fo[3:0],0,0,0), ins, "exec_r");
                    cycle(rb(), rb(), mk(0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,1,0), ins, "alu_wb");
                    m_ret++;
                end else begin
                    trap_cycles(ins);
                end
            end
            6'h23: begin
                cycle(rb(), rb(), mk(0,0,0,0,0,2'b00,1,2'b10,A_ADD,0,0,0), ins, "mem_addr");
                for (int i = 0; i < wm; i++)
                    cycle(1'b0, rb(), mk(1,0,1,0,0,2'b00,0,2'b00,4'b0000,0,0,0), ins, "mem_rd_wait");
                cycle(1'b1, rb(), mk(1,0,1,0,0,2'b00,0,2'b00,4'b0000,0,0,0), ins, "mem_rd");
                cycle(rb(), rb(), mk(0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,0,1), ins, "mem_wb");
                m_ret++;
            end
            6'h2B: begin
                cycle(rb(), rb(), mk(0,0,0,0,0,2'b00,1,2'b10,A_ADD,0,0,0), ins, "mem_addr");
                for (int i = 0; i < wm; i++)
                    cycle(1'b0, rb(), mk(0,1,1,0,0,2'b00,0,2'b00,4'b0000,0,0,0), ins, "mem_wr_wait");
                cycle(1'b1, rb(), mk(0,1,1,0,0,2'b00,0,2'b00,4'b0000,0,0,0), ins, "mem_wr");
                m_ret++;
            end
            6'h08: begin
                cycle(rb(), rb(), mk(0,0,0,0,0,2'b00,1,2'b10,A_ADD,0,0,0), ins, "addi_ex");
                cycle(rb(), rb(), mk(0,0,0,0,0,2'b00,0,2'b00,4'b0000,1,0,0), ins, "addi_wb");
                m_ret++;
            end
            6'h04: begin
                cycle(rb(), z, mk(0,0,0,0,z,2'b01,1,2'b00,A_SUB,0,0,0), ins, "beq");
                m_ret++;
            end
            6'h02: begin
                cycle(rb(), rb(), mk(0,0,0,0,1,2'b10,0,2'b00,4'b0000,0,0,0), ins, "jump");
                m_ret++;
            end
            default: trap_cycles(ins);
        endcase
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] f);
        logic [31:0] w;
        w       = $urandom;
        w[31:26] = 6'h00;
        w[5:0]   = f;
        return w;
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op);
        logic [31:0] w;
        w        = $urandom;
        w[31:26] = op;
        return w;
    endfunction

    // Monitor: one comparison per cycle that has a pending expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUScr,
                        ALUControl, RegWrite, RegDst, MemtoReg, illegal, retired};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", mon_name, mon_act, mon_exp);
            end
        end
    end

    initial begin
        logic [6:0] sel;
        do_reset(3);
        run_instr(32'h012A4020, 0, 0, 1'b0);
        for (int i = 1; i < 6; i++) run_instr(rtype(legal_f[i]), 0, 0, 1'b0);
        run_instr(itype(6'h23), 2, 3, 1'b0);
        run_instr(itype(6'h2B), 0, 0, 1'b0);
        run_instr(itype(6'h04), 0, 0, 1'b1);
        run_instr(itype(6'h04), 0, 0, 1'b0);
        run_instr(itype(6'h02), 0, 0, 1'b0);
        run_instr(itype(6'h08), 1, 0, 1'b0);

        // Abandon a load while it waits in the read cycle
        fetch_decode(32'h8D090004, 0);
        cycle(rb(), rb(), mk(0,0,0,0,0,2'b00,1,2'b10,A_ADD,0,0,0), 32'h8D090004, "mem_addr");
        cycle(1'b0, rb(), mk(1,0,1,0,0,2'b00,0,2'b00,4'b0000,0,0,0), 32'h8D090004, "mem_rd_wait");
        do_reset(3);
        run_instr(32'h8D090004, 0, 0, 1'b0);

        run_instr(itype(6'h3F), 0, 0, 1'b0);
        run_instr(rtype(6'h18), 0, 0, 1'b0);

        for (int i = 0; i < 17; i++) run_instr(itype(6'h02), 0, 0, 1'b0);
        cycle(1'b0, 1'b0, mk(1,0,0,0,0,2'b00,0,2'b01,A_ADD,0,0,0), 32'h08000000, "fetch_wait");
        @(negedge clk);
        n_cmp++;
        if (retired !== 4'd1) begin
            n_bad++;
            $display("FAIL wrap17: got %0d expected 1", retired);
        end
        do_reset(1);

        for (int n = 0; n < 150; n++) begin
            sel = 7'($urandom_range(31, 0));
            if (sel == 7'd30) begin
                run_instr(itype(bad_op[$urandom_range(3, 0)]), 0, 0, 1'b0);
            end else if (sel == 7'd31) begin
                run_instr(rtype(6'h18), 0, 0, 1'b0);
            end else begin
                case (sel % 7'd6)
                    7'd0:    run_instr(rtype(legal_f[$urandom_range(5, 0)]), $urandom_range(3, 0), 0, 1'b0);
                    7'd1:    run_instr(itype(6'h23), $urandom_range(3, 0), $urandom_range(3, 0), 1'b0);
                    7'd2:    run_instr(itype(6'h2B), $urandom_range(3, 0), $urandom_range(3, 0), 1'b0);
                    7'd3:    run_instr(itype(6'h08), $urandom_range(3, 0), 0, 1'b0);
                    7'd4:    run_instr(itype(6'h04), $urandom_range(3, 0), 0, rb());
                    default: run_instr(itype(6'h02), $urandom_range(3, 0), 0, 1'b0);
                endcase
            end
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
